// File: rtl/ov7670_capture_pkg.sv
// Shared constants and FSM encoding for the OV7670 capture path, reused by the
// frame-buffer and VGA-read blocks.
package ov7670_capture_pkg;

  localparam int DEF_H_PIX   = 320;
  localparam int DEF_V_LINES = 240;
  localparam int DEF_ADDR_W  = 17;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_e;

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser for one asynchronous camera strobe, with one-cycle
// rise/fall pulses taken from the synchronised level.
module cam_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  // [0] metastable stage, [1] synchronised level, [2] previous level
  logic [2:0] sr;

  // NOTE: state flops use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], d};
  end

  assign sync = sr[1];
  assign rise =  sr[1] & ~sr[2];
  assign fall = ~sr[1] &  sr[2];

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 parallel-bus capture: oversamples the camera bus on CLK_25M, pairs bytes
// into RGB565 words and emits frame-buffer writes with a linear address.
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int H_PIX   = DEF_H_PIX,
  parameter int V_LINES = DEF_V_LINES,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              CLK_25M,
  input  logic              RST_N,
  input  logic              INIT_DONE,
  input  logic              CAM_PCLK,
  input  logic              CAM_VSYNC,
  input  logic              CAM_HREF,
  input  logic [7:0]        CAM_D,
  output logic              WE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [15:0]       WDATA,
  output logic              FRAME_DONE,
  output logic [7:0]        FRAME_CNT,
  output logic              LINE_ERR
);

  localparam int COL_W  = $clog2(H_PIX + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(H_PIX);
  localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_LINES);

  logic pclk_sync, pclk_rise, pclk_fall;
  logic vs_sync, vs_rise, vs_fall;
  logic href_sync, href_rise, href_fall;
  logic [7:0] d_meta, d_sync;

  cam_sync_edge u_pclk (.clk(CLK_25M), .rst_n(RST_N), .d(CAM_PCLK),
                        .sync(pclk_sync), .rise(pclk_rise), .fall(pclk_fall));
  cam_sync_edge u_vs   (.clk(CLK_25M), .rst_n(RST_N), .d(CAM_VSYNC),
                        .sync(vs_sync), .rise(vs_rise), .fall(vs_fall));
  cam_sync_edge u_href (.clk(CLK_25M), .rst_n(RST_N), .d(CAM_HREF),
                        .sync(href_sync), .rise(href_rise), .fall(href_fall));

  logic unused;
  assign unused = ^{pclk_sync, pclk_fall, vs_sync, href_rise};

  // Data takes the same two-stage path as the strobes so the sample stays aligned
  always_ff @(posedge CLK_25M or negedge RST_N) begin
    if (!RST_N) begin
      d_meta <= '0;
      d_sync <= '0;
    end else begin
      d_meta <= CAM_D;
      d_sync <= d_meta;
    end
  end

  cap_state_e state_q, state_d;
  logic frame_start, frame_end;

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    if (!INIT_DONE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_WAIT_VS;
        ST_WAIT_VS: if (vs_fall) begin
          state_d     = ST_CAPTURE;
          frame_start = 1'b1;
        end
        ST_CAPTURE: if (vs_rise) begin
          state_d   = ST_WAIT_VS;
          frame_end = 1'b1;
        end
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_25M or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  logic [ADDR_W-1:0] addr_q;
  logic [COL_W-1:0]  col_q;
  logic [LINE_W-1:0] line_q;
  logic              phase_q;
  logic [7:0]        hi_q;
  logic              capturing, pix_take, in_range, wr;

  assign capturing = (state_q == ST_CAPTURE) && INIT_DONE;
  assign pix_take  = capturing && pclk_rise && href_sync;
  assign in_range  = (col_q < COL_MAX) && (line_q < LINE_MAX);
  assign wr        = pix_take && phase_q && in_range;

  always_ff @(posedge CLK_25M or negedge RST_N) begin
    if (!RST_N) begin
      WE         <= 1'b0;
      WADDR      <= '0;
      WDATA      <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_CNT  <= '0;
      LINE_ERR   <= 1'b0;
      addr_q     <= '0;
      col_q      <= '0;
      line_q     <= '0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
    end else begin
      WE         <= wr;
      FRAME_DONE <= frame_end;
      if (frame_end) FRAME_CNT <= FRAME_CNT + 8'd1;

      if (!INIT_DONE || frame_start) begin
        addr_q  <= '0;
        col_q   <= '0;
        line_q  <= '0;
        phase_q <= 1'b0;
      end else if (capturing) begin
        if (pix_take) begin
          if (!phase_q) begin
            hi_q    <= d_sync;
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            if (in_range) begin
              WDATA  <= {hi_q, d_sync};
              WADDR  <= addr_q;
              addr_q <= addr_q + ADDR_W'(1);
              col_q  <= col_q + COL_W'(1);
            end
          end
        end
        // Placed after the pixel update so a coincident line end wins on col/phase
        if (href_fall) begin
          if (col_q != COL_MAX && line_q < LINE_MAX) LINE_ERR <= 1'b1;
          col_q   <= '0;
          phase_q <= 1'b0;
          if (line_q < LINE_MAX) line_q <= line_q + LINE_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Downstream neighbour of the SCCB init block: consumes its INIT_DONE and turns the OV7670 parallel pixel bus into RGB565 words with linear frame-buffer write addresses.
- Runs entirely on CLK_25M. Camera PCLK/VSYNC/HREF/D are oversampled, so the camera is configured via its clock prescaler for PCLK ≤ 6.25 MHz.
- Output feeds the frame-buffer BRAM write port.

Parameters:
- H_PIX, 320, active pixels per line (16-bit words)
- V_LINES, 240, active lines per frame
- ADDR_W, 17, write-address width; 2^ADDR_W ≥ H_PIX*V_LINES

Ports:
- CLK_25M  in  1  system clock, 25 MHz
- RST_N  in  1  reset, asynchronous, active-low
- INIT_DONE  in  1  camera register init complete (from SCCB block)
- CAM_PCLK  in  1  camera pixel clock, async, sampled
- CAM_VSYNC  in  1  frame sync, high = vertical blank, async
- CAM_HREF  in  1  line valid, async
- CAM_D  in  8  camera data, async
- WE  out  1  one-cycle write strobe
- WADDR  out  ADDR_W  frame-buffer address
- WDATA  out  16  RGB565 pixel, {first byte, second byte}
- FRAME_DONE  out  1  one-cycle pulse at frame end
- FRAME_CNT  out  8  completed-frame counter, wraps 255→0
- LINE_ERR  out  1  sticky: a line ended with pixel count ≠ H_PIX

Behaviour:
- Reset: all outputs are 0; state is IDLE; every counter, pipeline and synchroniser flop is 0.
- Input path:
  - PCLK, VSYNC and HREF each pass through a 2-FF synchroniser. CAM_D passes through an identical 2-stage delay so it stays aligned.
  - Edge detect on the synchronised PCLK: pclk_rise is high for one cycle when sync_now=1 and sync_prev=0.
  - The HREF/D values sampled in the pclk_rise cycle are the "sample".
- FSM:
  - IDLE: when INIT_DONE=1, go to WAIT_VS.
  - WAIT_VS: wait until synchronised VSYNC has been seen high and then falls. On the fall, go to CAPTURE and clear the column, line and address counters and the byte phase.
  - CAPTURE: on a VSYNC rising edge, pulse FRAME_DONE for 1 cycle, increment FRAME_CNT and go to WAIT_VS. This also applies to short frames.
  - From any state, INIT_DONE=0 forces IDLE within 1 cycle. WE must not pulse while INIT_DONE=0. Counters clear; FRAME_CNT and LINE_ERR are held.
- Byte assembly (CAPTURE only, on pclk_rise with sampled HREF=1):
  - phase 0: latch byte into hi; set phase=1.
  - phase 1: WDATA←{hi, byte}; set phase=0.
  - In the phase-1 case, when col<H_PIX and line<V_LINES: assert WE in the next cycle, with WADDR = current address, then increment address and col.
  - Pixels beyond H_PIX, and lines beyond V_LINES, are dropped: no WE, address frozen.
- Latency: WE rises exactly 1 CLK_25M cycle after the pclk_rise cycle that completed the pixel. WDATA/WADDR are stable while WE=1 and held until the next write.
- Line end (falling edge of synchronised HREF):
  - If col≠H_PIX and line<V_LINES, set LINE_ERR. It clears only on reset.
  - Then col←0, phase←0, and line increments, saturating at V_LINES.
  - An odd byte count leaves a dangling phase-1 byte; it is discarded, not written.
- WADDR is a running counter, with no multiplier. A full frame ends at address H_PIX*V_LINES−1. The counter never wraps inside a frame; it saturates by the drop rule.
- Simultaneous events:
  - VSYNC rise in the same cycle as a pixel completion: the pixel's WE still issues (if in range), then FRAME_DONE follows in the same cycle as that WE.
  - An HREF fall coinciding with pclk_rise: process the pixel first, then the line end.
- FRAME_CNT increments modulo 256.

Decomposition:
- Shared package/header holds the FSM state encodings (IDLE, WAIT_VS, CAPTURE) and the default H_PIX/V_LINES/ADDR_W constants, for reuse by the frame-buffer and VGA-read blocks.
- One sub-module: cam_sync_edge, a 2-FF synchroniser plus rise/fall detect, instantiated for PCLK, VSYNC and HREF.

Test Plan:
- INIT_DONE=0 with full camera traffic → WE, FRAME_DONE and FRAME_CNT all stay 0; raising INIT_DONE mid-frame → no WE until after the next VSYNC high→low.
- One frame with H_PIX=4, V_LINES=2, bytes 0x01..0x10 → 8 WE pulses, WDATA 0x0102, 0x0304, …, 0x0F10, WADDR 0..7, 1 FRAME_DONE, FRAME_CNT=1, LINE_ERR=0.
- Line with 12 bytes (6 pixels) at H_PIX=4 → only 4 writes, address ends at 3, next line starts at 4, LINE_ERR stays 0.
- Line with 5 bytes → 2 writes, dangling byte discarded, LINE_ERR=1 and held through later good frames.
- Drop RST_N mid-line → all outputs 0 asynchronously; after release, capture resumes only after a VSYNC high→low; FRAME_CNT restarts at 0.
- 256 consecutive frames → FRAME_CNT wraps to 0; measure the pclk_rise→WE gap as exactly 1 cycle on every pixel.
